// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: loader FSM states, frame sync marker
// and the instruction-memory / program-counter geometry the loader writes into.
package prog_loader_pkg;

    localparam int IMEM_ADDR_W = 13;
    localparam int IMEM_DATA_W = 14;
    localparam int PC_W        = IMEM_ADDR_W;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    // Word count carried by the frame header: low five bits of CNT_HI over CNT_LO.
    function automatic logic [12:0] frame_count(input logic [4:0] cnt_hi, input logic [7:0] cnt_lo);
        return {cnt_hi, cnt_lo};
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a framed image, writes 14-bit words to
// instruction memory from address 0, holds the core while loading and checks the sum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W    = IMEM_ADDR_W,
    parameter int         DATA_W    = IMEM_DATA_W,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic              started_q;
    logic [5:0]        hi_q, hi_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [7:0]        sum_q, sum_d;

    logic              accept;
    logic              is_sync;
    logic [12:0]       count;

    // started_q keeps the interface closed for the first cycle after reset release.
    assign in_ready = started_q && (state_q != WRITE);
    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign count    = frame_count(hi_q[4:0], in_data);

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        word_d   = word_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        sum_d    = sum_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (accept && is_sync) begin
                    addr_d  = '0;
                    sum_d   = 8'h00;
                    state_d = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    hi_d    = in_data[5:0];
                    sum_d   = sum_q + in_data;
                    state_d = (in_data[7:5] != 3'b000) ? ERR : CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    sum_d    = sum_q + in_data;
                    remain_d = ADDR_W'(count);
                    state_d  = (count == 13'd0) ? CHECK : DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data[5:0];
                    sum_d   = sum_q + in_data;
                    state_d = (in_data[7:6] != 2'b00) ? ERR : DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    sum_d   = sum_q + in_data;
                    word_d  = DATA_W'({hi_q, in_data});
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - ADDR_W'(1);
                state_d  = (remain_q == ADDR_W'(1)) ? CHECK : DATA_HI;
            end
            CHECK: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? DONE : ERR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            hi_q      <= '0;
            word_q    <= '0;
            addr_q    <= '0;
            remain_q  <= '0;
            sum_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            hi_q      <= hi_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            sum_q     <= sum_d;
        end
    end

    // Status is decoded from the registered state, so it is glitch-free and mutually exclusive.
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
    assign cpu_hold  = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected memory writes go into a scoreboard
// queue when a frame is built and are popped by a monitor whenever mem_we fires.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [13:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] addr;
        logic [13:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame_q[$];
    int         checks_total  = 0;
    int         checks_passed = 0;
    int         cyc = 0;
    bit         ready_chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the oldest expected write, and
    // in_ready must be low exactly while the strobe is high.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            checks_total++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data)
                    $display("[TB] FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                else
                    checks_passed++;
            end
        end
        if (ready_chk_en) begin
            checks_total++;
            if (in_ready !== ~mem_we)
                $display("[TB] FAIL ready_vs_write: got in_ready=%b mem_we=%b, expected in_ready=!mem_we", in_ready, mem_we);
            else
                checks_passed++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks_total++;
            $display("[TB] FAIL handshake_timeout: got in_ready=%b, expected 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frame_q[i]) send_byte(frame_q[i], max_gap);
    endtask

    // Builds a random n-word frame, computing the checksum independently and
    // queueing the writes it should produce.
    task automatic build_frame(input int n, input bit good_cksum);
        logic [7:0]  sum;
        logic [13:0] w;
        logic [12:0] cnt;
        wr_t         e;
        cnt = 13'(n);
        sum = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back({3'b000, cnt[12:8]});
        frame_q.push_back(cnt[7:0]);
        sum = sum + {3'b000, cnt[12:8]} + cnt[7:0];
        for (int i = 0; i < n; i++) begin
            w = 14'($urandom);
            frame_q.push_back({2'b00, w[13:8]});
            frame_q.push_back(w[7:0]);
            sum = sum + {2'b00, w[13:8]} + w[7:0];
            e.addr = 13'(i);
            e.data = w;
            exp_q.push_back(e);
        end
        frame_q.push_back(good_cksum ? sum : sum + 8'h01);
    endtask

    task automatic check_status(input string name, input logic exp_done, input logic exp_err, input logic exp_hold);
        checks_total++;
        if ({done, error, cpu_hold} !== {exp_done, exp_err, exp_hold})
            $display("[TB] FAIL %s: got done/error/hold=%b%b%b, expected %b%b%b",
                     name, done, error, cpu_hold, exp_done, exp_err, exp_hold);
        else
            checks_passed++;
    endtask

    task automatic check_drained(input string name);
        checks_total++;
        if (exp_q.size() != 0)
            $display("[TB] FAIL %s: got %0d pending writes, expected 0", name, exp_q.size());
        else
            checks_passed++;
        exp_q.delete();
    endtask

    task automatic do_reset();
        ready_chk_en = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ready_chk_en = 1'b1;
    endtask

    task automatic test_reset();
        ready_chk_en = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        checks_total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== 30'd0)
            $display("[TB] FAIL reset_values: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, expected all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
        else
            checks_passed++;
        reset = 1'b0;
        #1;
        checks_total++;
        if (in_ready !== 1'b0)
            $display("[TB] FAIL first_cycle_ready: got %b, expected 0", in_ready);
        else
            checks_passed++;
        @(negedge clk);
        checks_total++;
        if (in_ready !== 1'b1)
            $display("[TB] FAIL idle_ready: got %b, expected 1", in_ready);
        else
            checks_passed++;
        ready_chk_en = 1'b1;
    endtask

    task automatic test_normal_load();
        wr_t e;
        check_status("hold_before_sync", 1'b0, 1'b0, 1'b0);
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h3F, 8'hFF, 8'h12, 8'h34, 8'h86};
        e.addr = 13'd0; e.data = 14'h3FFF; exp_q.push_back(e);
        e.addr = 13'd1; e.data = 14'h1234; exp_q.push_back(e);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], 0);
            if (i == 0) check_status("hold_after_sync", 1'b0, 1'b0, 1'b1);
        end
        check_status("normal_done", 1'b1, 1'b0, 1'b0);
        check_drained("normal_writes");
    endtask

    task automatic test_empty_image();
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        check_status("empty_done", 1'b1, 1'b0, 1'b0);
        check_drained("empty_writes");
    endtask

    task automatic test_bad_checksum();
        wr_t e;
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h07, 8'h00};
        e.addr = 13'd0; e.data = 14'h0007; exp_q.push_back(e);
        send_frame(0);
        check_status("bad_cksum_err", 1'b0, 1'b1, 1'b1);
        check_drained("bad_cksum_writes");
        send_byte(8'hA5, 0);
        check_status("sync_clears_err", 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_status("recover_done", 1'b1, 1'b0, 1'b0);
        build_frame(2, 1'b0);
        send_frame(1);
        check_status("rand_bad_cksum_err", 1'b0, 1'b1, 1'b1);
        check_drained("rand_bad_cksum_writes");
    endtask

    task automatic test_illegal_bytes();
        frame_q = '{8'hA5, 8'h20};
        send_frame(0);
        check_status("cnt_hi_illegal", 1'b0, 1'b1, 1'b1);
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h40, 8'h00, 8'h41};
        send_frame(0);
        check_status("w_hi_illegal", 1'b0, 1'b1, 1'b1);
        check_drained("w_hi_no_write");
    endtask

    task automatic test_back_to_back();
        int c0;
        build_frame(5, 1'b1);
        c0 = 0;
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], 0);
            if (i == 0) c0 = cyc;
        end
        check_status("b2b_done", 1'b1, 1'b0, 1'b0);
        checks_total++;
        if (cyc - c0 + 1 != 3 + 3 * 5 + 1)
            $display("[TB] FAIL b2b_cycles: got %0d, expected %0d", cyc - c0 + 1, 3 + 3 * 5 + 1);
        else
            checks_passed++;
        check_drained("b2b_writes");
    endtask

    task automatic test_gaps();
        build_frame(6, 1'b1);
        send_frame(3);
        check_status("gaps_done", 1'b1, 1'b0, 1'b0);
        check_drained("gaps_writes");
    endtask

    task automatic test_garbage();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        check_status("garbage_idle", 1'b0, 1'b0, 1'b0);
        build_frame(3, 1'b1);
        send_frame(0);
        check_status("garbage_done", 1'b1, 1'b0, 1'b0);
        check_drained("garbage_writes");
    endtask

    task automatic test_reset_mid_frame();
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00};
        send_frame(0);
        ready_chk_en = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        reset    = 1'b1;
        #1;
        checks_total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== 30'd0)
            $display("[TB] FAIL mid_reset_outputs: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, expected all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
        else
            checks_passed++;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        ready_chk_en = 1'b1;
        check_status("after_mid_reset", 1'b0, 1'b0, 1'b0);
        check_drained("mid_reset_no_write");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        test_reset();
        test_normal_load();
        test_empty_image();
        test_bad_checksum();
        test_illegal_bytes();
        test_back_to_back();
        test_gaps();
        test_garbage();
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
